// File: rtl/imm_pack_if.sv
// rtl/imm_pack_if.sv - constant-in / immediate-chunk-out handshake bundle for imm_pack
interface imm_pack_if #(
  parameter int IMM_W  = 3,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [IMM_W-1:0]  out_chunk;
  logic              out_first;
  logic              out_last;
  logic              out_fits;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_chunk, out_first, out_last, out_fits
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_chunk, out_first, out_last, out_fits
  );
endinterface

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - splits a signed constant into the fewest IMM_W-bit immediate chunks, MS first
module imm_pack #(
  parameter int IMM_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  imm_pack_if.slave   bus
);
  localparam int K_MAX = (DATA_W + IMM_W) / IMM_W;
  localparam int SW    = K_MAX * IMM_W;
  localparam int CW    = $clog2(K_MAX + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    sr_q, sr_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             first_q, first_d;
  logic             fits_q, fits_d;

  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] probe;
  logic [CW-1:0]        k_sel;
  int                   shamt;

  // k fits when every bit from k*IMM_W-1 upward is a copy of the sign;
  // scanning downward leaves the smallest fitting k selected.
  always_comb begin
    ext   = {{(SW-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
    k_sel = CW'(K_MAX);
    probe = '0;
    for (int k = K_MAX; k >= 1; k--) begin
      probe = ext >>> (k * IMM_W - 1);
      if (probe == '0 || probe == '1) begin
        k_sel = CW'(k);
      end
    end
    shamt = SW - int'(k_sel) * IMM_W;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rem_d   = rem_q;
    first_d = first_q;
    fits_d  = fits_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = ext << shamt;
          rem_d   = k_sel;
          first_d = 1'b1;
          fits_d  = (k_sel == CW'(1));
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          first_d = 1'b0;
          if (rem_q == CW'(1)) begin
            state_d = IDLE;
          end else begin
            sr_d  = sr_q << IMM_W;
            rem_d = rem_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      fits_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      fits_q  <= fits_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_chunk = sr_q[SW-1 -: IMM_W];
  assign bus.out_first = first_q;
  assign bus.out_last  = (state_q == SEND) && (rem_q == CW'(1));
  assign bus.out_fits  = fits_q;
endmodule

// File: doc/imm_pack.md
# imm_pack

Inverse of the immediate sign-extender: accepts a 32-bit signed constant and serialises it, most-significant chunk first, into the minimum number of IMM_W-bit immediate chunks. A downstream loader rebuilds the word by sign-extending the first chunk and then shift-appending each later chunk. The block sits between the constant source (test bench or instruction assembler path) and the immediate field of the datapath. It flags constants that fit in a single immediate.

## Interface
- IMM_W, 3, immediate field width in bits (≥2)
- DATA_W, 32, constant width
- K_MAX, ceil((DATA_W+1)/IMM_W) = 11, maximum chunk count (derived localparam)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_data is offered
- in_ready  output  1  block can accept a constant
- in_data  input  DATA_W  signed constant
- out_valid  output  1  out_chunk is valid
- out_ready  input  1  consumer takes the chunk
- out_chunk  output  IMM_W  current chunk, MS first
- out_first  output  1  current chunk is the sign-carrying first chunk
- out_last  output  1  current chunk is the final chunk
- out_fits  output  1  constant needs exactly one chunk; held for the whole burst

## Operation
- States: IDLE and SEND.
- IDLE:
  - in_ready=1 and out_valid=0.
  - When in_valid&&in_ready, latch the constant and compute k.
  - k is the smallest value in 1..K_MAX such that in_data lies in [-2^(k·IMM_W-1), 2^(k·IMM_W-1)-1].
  - Load the shift register with in_data sign-extended to K_MAX·IMM_W bits, then left-aligned so that chunk 0 = bits [k·IMM_W-1 -: IMM_W] of the sign-extended value.
  - Set remaining=k, set out_fits=(k==1), and go to SEND.
- SEND:
  - in_ready=0; out_valid=1.
  - out_chunk is the top IMM_W bits of the shift register.
  - out_first=1 on the first chunk only; out_last=(remaining==1).
  - On out_valid&&out_ready:
    - If out_last, go to IDLE.
    - Otherwise shift left by IMM_W, decrement remaining, and clear out_first.
  - With out_ready=0, all out_* outputs stay stable.
- Reconstruction invariant: acc = sext(chunk0), then acc = (acc<<IMM_W)|chunkN for each later chunk; the result equals in_data.
- Arithmetic:
  - k computation is combinational on in_data, using one comparison per k, with a priority-select of the smallest k.
  - remaining uses a counter of width clog2(K_MAX+1).
- Only one constant is in flight at a time. The block never accepts new input while in SEND.

## Timing
- Reset (rst high at an edge):
  - State=IDLE, out_valid=0, out_first=0, out_last=0, out_fits=0, out_chunk=0, remaining=0.
  - in_ready is forced 0 while rst is high and is 1 on the first cycle after release.
- Reset mid-burst aborts immediately: no out_last is issued and the partial burst is discarded.
- Accept at edge T gives out_valid=1 from T+1, with chunk 0 visible at T+1.
- Minimum burst occupancy is k cycles. in_ready returns to 1 the cycle after the last-chunk handshake, so the throughput is one constant per k+1 cycles.
- in_valid asserted while in SEND is ignored; the source must hold in_data until in_ready.
- out_fits, out_first and out_last are registered or derived from registered state only. They have no combinational path from in_* to out_*.
- out_ready low for any number of cycles stalls the burst without loss or duplication.

## Test plan
- in_data=3 → one chunk 3'b011; out_first=out_last=out_fits=1.
- in_data=-4 (0xFFFFFFFC) → one chunk 3'b100; out_fits=1.
- in_data=4 → two chunks, 3'b000 then 3'b100; out_fits=0. in_data=-5 → 3'b111 then 3'b011.
- in_data=0x7FFFFFFF → 11 chunks: 3'b001 followed by ten 3'b111. in_data=0x80000000 → 3'b110 followed by ten 3'b000. Reconstruction must match in every case.
- Backpressure: for in_data=4, hold out_ready=0 for 5 cycles on each chunk. out_chunk, out_first and out_last must stay stable, in_ready must stay 0, and exactly 2 handshakes must occur.
- Reset at the 4th chunk of 0x7FFFFFFF:
  - The next cycle shows out_valid=0 and in_ready=1 once rst falls.
  - The following constant 3 is emitted correctly as a single chunk.
- Random regression: 1000 random in_data values with random out_ready. The reconstructed value must equal in_data, and the chunk count must equal the minimal k.
